// File: rtl/sys_cmd_pkg.sv
// rtl/sys_cmd_pkg.sv - shared constants and types for the command framer
// Purpose: frame header bytes, command type encodings, framer FSM states.
// Ports: none (package).
package sys_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CT_WRITE   = 2'd0,
    CT_READ    = 2'd1,
    CT_ALU_OP  = 2'd2,
    CT_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4
  } state_e;

  // State that carries the final byte of a frame of the given type.
  function automatic state_e last_state(cmd_type_e t);
    case (t)
      CT_WRITE:  return ST_B2;
      CT_ALU_OP: return ST_B3;
      default:   return ST_B1;
    endcase
  endfunction

endpackage

// File: rtl/rsp_credit_cnt.sv
// rtl/rsp_credit_cnt.sv - outstanding-response counter with underflow flag
// Purpose: counts response-producing frames in flight.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   inc_i            a response-producing frame finished sending
//   dec_i            one response fully received
//   count_o          frames in flight
//   full_o           count_o has reached MAX_OUTSTANDING
//   err_o            sticky: dec_i arrived with nothing outstanding
module rsp_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       full_o,
  output logic       err_o
);

  logic [3:0] count_q, count_d;
  logic       err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    // Simultaneous inc and dec cancel out, so only the one-sided cases move.
    if (inc_i && !dec_i) begin
      count_d = count_q + 4'd1;
    end else if (dec_i && !inc_i) begin
      if (count_q == 4'd0) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q >= 4'(MAX_OUTSTANDING));
  assign err_o   = err_q;

endmodule

// File: rtl/sys_cmd_framer.sv
// rtl/sys_cmd_framer.sv - serialises host commands into controller byte frames
// Purpose: accepts one command per handshake, emits its byte frame to the
//          UART transmitter and tracks response credit.
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_type/addr/data/op_b/fun      command fields, latched on accept
//   byte_data/byte_valid/byte_ready  byte stream to the transmitter
//   rsp_done                         one response received
//   outstanding, rsp_err             credit count and underflow flag
module sys_cmd_framer
  import sys_cmd_pkg::*;
#(
  parameter int BUS_WIDTH       = 8,
  parameter int Reg_Addr        = 4,
  parameter int ALU_FUN         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [Reg_Addr-1:0]  cmd_addr,
  input  logic [BUS_WIDTH-1:0] cmd_data,
  input  logic [BUS_WIDTH-1:0] cmd_op_b,
  input  logic [ALU_FUN-1:0]   cmd_fun,
  output logic [BUS_WIDTH-1:0] byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  input  logic                 rsp_done,
  output logic [3:0]           outstanding,
  output logic                 rsp_err
);

  state_e               state_q, state_d;
  cmd_type_e            type_q;
  logic [Reg_Addr-1:0]  addr_q;
  logic [BUS_WIDTH-1:0] data_q, opb_q;
  logic [ALU_FUN-1:0]   fun_q;

  logic accept, hs, last_hs, inc, full;

  assign cmd_ready = (state_q == ST_IDLE) && !full;
  assign accept    = cmd_valid && cmd_ready;
  assign hs        = byte_valid && byte_ready;
  assign last_hs   = hs && (state_q == last_state(type_q));
  assign inc       = last_hs && (type_q != CT_WRITE);

  // State register and command field latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      type_q  <= CT_WRITE;
      addr_q  <= '0;
      data_q  <= '0;
      opb_q   <= '0;
      fun_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q <= cmd_type_e'(cmd_type);
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        opb_q  <= cmd_op_b;
        fun_q  <= cmd_fun;
      end
    end
  end

  // Next state: every move past HDR waits on a byte handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_HDR;
      ST_HDR:  if (hs) state_d = ST_B1;
      ST_B1:   if (hs) state_d = last_hs ? ST_IDLE : ST_B2;
      ST_B2:   if (hs) state_d = last_hs ? ST_IDLE : ST_B3;
      ST_B3:   if (hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte mux: driven purely from registered state, so data holds through stalls.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = '0;
    case (state_q)
      ST_HDR: begin
        byte_valid = 1'b1;
        case (type_q)
          CT_WRITE:  byte_data = BUS_WIDTH'(CMD_WR);
          CT_READ:   byte_data = BUS_WIDTH'(CMD_RD);
          CT_ALU_OP: byte_data = BUS_WIDTH'(CMD_ALU_OP);
          default:   byte_data = BUS_WIDTH'(CMD_ALU_NOP);
        endcase
      end
      ST_B1: begin
        byte_valid = 1'b1;
        case (type_q)
          CT_ALU_OP:  byte_data = data_q;
          CT_ALU_NOP: byte_data = BUS_WIDTH'(fun_q);
          default:    byte_data = BUS_WIDTH'(addr_q);
        endcase
      end
      ST_B2: begin
        byte_valid = 1'b1;
        byte_data  = (type_q == CT_ALU_OP) ? opb_q : data_q;
      end
      ST_B3: begin
        byte_valid = 1'b1;
        byte_data  = BUS_WIDTH'(fun_q);
      end
      default: begin
        byte_valid = 1'b0;
        byte_data  = '0;
      end
    endcase
  end

  rsp_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (inc),
    .dec_i  (rsp_done),
    .count_o(outstanding),
    .full_o (full),
    .err_o  (rsp_err)
  );

endmodule

// File: tb/tb_sys_cmd_framer.sv
// tb/tb_sys_cmd_framer.sv - self-checking bench for sys_cmd_framer
module tb_sys_cmd_framer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'd0;
  logic [3:0] cmd_addr = 4'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [7:0] cmd_op_b = 8'd0;
  logic [3:0] cmd_fun = 4'd0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       rsp_done = 1'b0;
  logic [3:0] outstanding;
  logic       rsp_err;

  int checks = 0;
  int errors = 0;

  sys_cmd_framer #(
    .BUS_WIDTH(8), .Reg_Addr(4), .ALU_FUN(4), .MAX_OUTSTANDING(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .rsp_done(rsp_done), .outstanding(outstanding), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]      typ;
    logic [3:0]      addr;
    logic [7:0]      data;
    logic [7:0]      opb;
    logic [3:0]      fun;
    int              nb;
    logic [3:0][7:0] bytes;
    int              stall_idx;
    int              stall_len;
    bit              rsp_last;
    logic [3:0]      exp_out;
    bit              exp_ready;
  } vec_t;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] b, input logic [3:0] f, input int nb,
                              input logic [31:0] bytes, input int si, input int sl,
                              input bit rl, input logic [3:0] eo, input bit er);
    vec_t v;
    v.typ = t; v.addr = a; v.data = d; v.opb = b; v.fun = f; v.nb = nb;
    v.bytes = bytes; v.stall_idx = si; v.stall_len = sl; v.rsp_last = rl;
    v.exp_out = eo; v.exp_ready = er;
    return v;
  endfunction

  // Drives one command and checks every byte of its frame; bytes are packed
  // with byte 0 in the most significant position of the 32-bit table word.
  task automatic send_frame(input vec_t v, input string tag);
    logic [7:0] eb;
    cmd_valid = 1'b1; cmd_type = v.typ; cmd_addr = v.addr;
    cmd_data = v.data; cmd_op_b = v.opb; cmd_fun = v.fun; byte_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
    cmd_op_b = 8'($urandom); cmd_fun = 4'($urandom);
    for (int i = 0; i < v.nb; i++) begin
      eb = v.bytes[3-i];
      chk({tag, "_valid"}, 32'(byte_valid), 32'd1);
      chk({tag, "_byte"}, 32'(byte_data), 32'(eb));
      if (i == v.stall_idx) begin
        byte_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          step();
          chk({tag, "_stall_valid"}, 32'(byte_valid), 32'd1);
          chk({tag, "_stall_byte"}, 32'(byte_data), 32'(eb));
        end
        byte_ready = 1'b1;
      end
      if (i == v.nb - 1 && v.rsp_last) rsp_done = 1'b1;
      step();
      rsp_done = 1'b0;
    end
    chk({tag, "_end_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_end_out"}, 32'(outstanding), 32'(v.exp_out));
    chk({tag, "_end_ready"}, 32'(cmd_ready), 32'(v.exp_ready));
  endtask

  task automatic do_reset();
    RST = 1'b1; cmd_valid = 1'b0; byte_ready = 1'b0; rsp_done = 1'b0;
    step();
    RST = 1'b0;
  endtask

  vec_t tbl[4];
  vec_t rd;

  // Reference model state for the random phase.
  logic [7:0] q[$];
  logic [1:0] cur_t;
  int         mcnt;
  bit         merr;
  bit         acc, inc, dec;

  initial begin
    // Cumulative outstanding: WRITE none, then ALU_OP, READ, ALU_NOP each add one.
    tbl[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 3, 32'hAA053C00, -1, 0, 1'b0, 4'd0, 1'b1);
    tbl[1] = mk(2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 4, 32'hCC123402,  2, 3, 1'b0, 4'd1, 1'b1);
    tbl[2] = mk(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 2, 32'hBB0A0000,  0, 1, 1'b0, 4'd2, 1'b1);
    tbl[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 4'hF, 2, 32'hDD0F0000,  1, 2, 1'b0, 4'd3, 1'b1);

    do_reset();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_data", 32'(byte_data), 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i], $sformatf("tbl%0d", i));
      step();
    end

    // Credit limit: four READs fill MAX_OUTSTANDING=4.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd = mk(2'd1, 4'(i + 1), 8'h00, 8'h00, 4'h0, 2, {8'hBB, 4'h0, 4'(i + 1), 16'h0},
              -1, 0, 1'b0, 4'(i + 1), (i < 3));
      send_frame(rd, $sformatf("rd%0d", i));
    end
    cmd_valid = 1'b1; cmd_type = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_ready", 32'(cmd_ready), 32'd0);
      chk("full_valid", 32'(byte_valid), 32'd0);
      chk("full_out", 32'(outstanding), 32'd4);
    end
    cmd_valid = 1'b0;
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("credit_out", 32'(outstanding), 32'd3);
    chk("credit_ready", 32'(cmd_ready), 32'd1);
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("credit_out2", 32'(outstanding), 32'd2);

    // ALU_NOP whose last handshake coincides with rsp_done at outstanding=2.
    rd = mk(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 2, 32'hDD070000, -1, 0, 1'b1, 4'd2, 1'b1);
    send_frame(rd, "nop_coinc");

    // Underflow flag is sticky until reset.
    do_reset();
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("uf_err", 32'(rsp_err), 32'd1);
    chk("uf_out", 32'(outstanding), 32'd0);
    step(); step();
    chk("uf_sticky", 32'(rsp_err), 32'd1);

    // Reset mid-WRITE while the address byte is on the wire.
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 4'h9; cmd_data = 8'h55;
    byte_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort_pre_byte", 32'(byte_data), 32'h09);
    RST = 1'b1; step(); RST = 1'b0;
    chk("abort_valid", 32'(byte_valid), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_out", 32'(outstanding), 32'd0);
    chk("abort_err", 32'(rsp_err), 32'd0);
    step();
    chk("abort_idle", 32'(byte_valid), 32'd0);
    rd = mk(2'd1, 4'h6, 8'h00, 8'h00, 4'h0, 2, 32'hBB060000, -1, 0, 1'b0, 4'd1, 1'b1);
    send_frame(rd, "post_abort");

    // Random traffic against a byte-queue model of the frame format.
    do_reset();
    q.delete(); mcnt = 0; merr = 1'b0; cur_t = 2'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_ready", 32'(cmd_ready), 32'(q.size() == 0 && mcnt < 4));
      chk("rnd_valid", 32'(byte_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_byte", 32'(byte_data), 32'(q[0]));
      chk("rnd_out", 32'(outstanding), 32'(mcnt));
      chk("rnd_err", 32'(rsp_err), 32'(merr));

      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_type   = 2'($urandom);
      cmd_addr   = 4'($urandom);
      cmd_data   = 8'($urandom);
      cmd_op_b   = 8'($urandom);
      cmd_fun    = 4'($urandom);
      byte_ready = ($urandom_range(0, 9) < 7);
      rsp_done   = (mcnt > 0) && ($urandom_range(0, 9) < 2);

      acc = cmd_valid && (q.size() == 0) && (mcnt < 4);
      inc = 1'b0;
      if (q.size() != 0 && byte_ready) begin
        void'(q.pop_front());
        if (q.size() == 0 && cur_t != 2'd0) inc = 1'b1;
      end
      if (acc) begin
        cur_t = cmd_type;
        case (cmd_type)
          2'd0: begin q.push_back(8'hAA); q.push_back({4'h0, cmd_addr}); q.push_back(cmd_data); end
          2'd1: begin q.push_back(8'hBB); q.push_back({4'h0, cmd_addr}); end
          2'd2: begin q.push_back(8'hCC); q.push_back(cmd_data); q.push_back(cmd_op_b);
                      q.push_back({4'h0, cmd_fun}); end
          default: begin q.push_back(8'hDD); q.push_back({4'h0, cmd_fun}); end
        endcase
      end
      dec = rsp_done;
      if (inc && !dec) mcnt++;
      else if (dec && !inc) begin
        if (mcnt == 0) merr = 1'b1;
        else mcnt--;
      end
      step();
    end
    cmd_valid = 1'b0; rsp_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
